// File: rtl/memory_store_buffer.sv
// memory_store_buffer
//   Posted-write buffer sitting between the EX/MEM register and the data
//   memory. Stores are accepted in one cycle into a circular FIFO and drained
//   to memory in program order whenever the memory port is free. Loads go to
//   memory, or are served from the youngest matching buffered store.
//   This block is the only driver of the data memory control/address/data pins.
//
//   Handshake: a request transfers in a cycle where its valid and ready are both
//   high; ready never depends on the same-kind valid. Stores win over loads:
//   while st_valid_i is high, ld_ready_o is low and the load must be held.
//
//   Build option STORE_BUFFER_FWD_EN:
//     defined   - matching loads are forwarded from the youngest buffered store.
//     undefined - matching loads are stalled until the buffer no longer holds
//                 the address, then read from memory.
module memory_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic              st_ready_o,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    output logic              ld_ready_o,
    output logic              ld_rvalid_o,
    output logic [DATA_W-1:0] ld_rdata_o,
    output logic              buf_empty_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_writedata_o,
    input  logic [DATA_W-1:0] mem_readdata_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    // Owner of the memory port in the current cycle.
    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_LOAD  = 2'd1,
        GNT_DRAIN = 2'd2
    } grant_e;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic              ld_rvalid_q, ld_rvalid_d;
    logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

    logic   full;
    logic   push;
    logic   pop;
    logic   ld_match;
    logic   ld_accept;
    logic   ld_to_mem;
    grant_e grant;

`ifdef STORE_BUFFER_FWD_EN
    logic [DATA_W-1:0] hit_data;
`endif

    assign full        = (count_q == CW'(DEPTH));
    assign st_ready_o  = !full;
    assign buf_empty_o = (count_q == '0);
    assign push        = st_valid_i && st_ready_o;

    // Associative search over the live entries, oldest to youngest, so the
    // last match found is the youngest. Uses pre-push / pre-pop contents, so
    // the head being drained this cycle still counts as a match.
    always_comb begin
        ld_match = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        hit_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == ld_addr_i)) begin
                ld_match = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                hit_data = data_q[head_q + PW'(i)];
`endif
            end
        end
    end

    // Load acceptance: stores take priority, a full buffer must drain first,
    // and without forwarding a matching load waits for the buffer to drain.
    always_comb begin
`ifdef STORE_BUFFER_FWD_EN
        ld_ready_o = !st_valid_i && !full;
`else
        ld_ready_o = !st_valid_i && !full && !ld_match;
`endif
        ld_accept = ld_valid_i && ld_ready_o;
        ld_to_mem = ld_accept && !ld_match;
    end

    // Memory port arbitration: full drain, then missing load, then background drain.
    always_comb begin
        grant = GNT_IDLE;
        if (full) begin
            grant = GNT_DRAIN;
        end else if (ld_to_mem) begin
            grant = GNT_LOAD;
        end else if (count_q != '0) begin
            grant = GNT_DRAIN;
        end
    end

    // Drive the data memory pins from the grant; zeros when idle.
    always_comb begin
        mem_write_o     = 1'b0;
        mem_read_o      = 1'b0;
        mem_address_o   = '0;
        mem_writedata_o = '0;
        pop             = 1'b0;
        case (grant)
            GNT_LOAD: begin
                mem_read_o    = 1'b1;
                mem_address_o = ld_addr_i;
            end
            GNT_DRAIN: begin
                mem_write_o     = 1'b1;
                mem_address_o   = addr_q[head_q];
                mem_writedata_o = data_q[head_q];
                pop             = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // FIFO pointer and occupancy next state; push and pop together keep the count.
    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Load result next state: one-cycle valid pulse, data held otherwise.
    always_comb begin
        ld_rvalid_d = ld_accept;
        ld_rdata_d  = ld_rdata_q;
        if (ld_accept) begin
`ifdef STORE_BUFFER_FWD_EN
            ld_rdata_d = ld_match ? hit_data : mem_readdata_i;
`else
            ld_rdata_d = mem_readdata_i;
`endif
        end
    end

    // Control state; reset discards pending stores and any in-flight load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ld_rvalid_q <= 1'b0;
            ld_rdata_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ld_rvalid_q <= ld_rvalid_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr_i;
            data_q[tail_q] <= st_data_i;
        end
    end

    assign ld_rvalid_o = ld_rvalid_q;
    assign ld_rdata_o  = ld_rdata_q;

endmodule
